// File: rtl/mem_pkg.sv
// Shared memory-interface definitions: funct3 load/store encodings, responder FSM
// encoding, request bundle and the request legality rule.
package mem_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic        write;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Unknown op, unsigned store, misaligned half/word, or address past the array.
  function automatic logic mem_req_illegal(input mem_req_t r, input int unsigned depth);
    logic bad;
    bad = 1'b0;
    case (r.op)
      MEM_B, MEM_BU: bad = 1'b0;
      MEM_H, MEM_HU: bad = r.addr[0];
      MEM_W:         bad = |r.addr[1:0];
      default:       bad = 1'b1;
    endcase
    if (r.write && (r.op == MEM_BU || r.op == MEM_HU)) bad = 1'b1;
    if ({2'b00, r.addr[31:2]} >= depth) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Little-endian lane handling: load extract with sign/zero extension, and store
// merge producing the updated word plus the per-lane write mask.
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [NUM_LANES-1:0][7:0] word,
  input  logic [31:0]               wdata,
  input  logic [1:0]                off,
  input  logic [2:0]                op,
  output logic [31:0]               ld_data,
  output logic [NUM_LANES-1:0][7:0] st_word,
  output logic [NUM_LANES-1:0]      st_mask
);

  logic [7:0]                ld_b;
  logic [15:0]               ld_h;
  logic [NUM_LANES-1:0][7:0] st_rep;

  assign ld_b = word[off];
  assign ld_h = off[1] ? word[3:2] : word[1:0];

  always_comb begin
    ld_data = word;
    case (op)
      MEM_B:   ld_data = {{24{ld_b[7]}}, ld_b};
      MEM_BU:  ld_data = {24'h0, ld_b};
      MEM_H:   ld_data = {{16{ld_h[15]}}, ld_h};
      MEM_HU:  ld_data = {16'h0, ld_h};
      default: ld_data = word;
    endcase
  end

  // Replicate the right-aligned store data so every candidate lane sees it.
  always_comb begin
    st_rep = wdata;
    case (op)
      MEM_B:   st_rep = {4{wdata[7:0]}};
      MEM_H:   st_rep = {2{wdata[15:0]}};
      default: st_rep = wdata;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign st_mask[i] = (op == MEM_B) ? (off == 2'(i)) :
                        (op == MEM_H) ? (off[1] == 1'(i >> 1)) : 1'b1;
    assign st_word[i] = st_mask[i] ? st_rep[i] : word[i];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage data responder: one request at a time, fixed wait states, owns the
// word storage and returns a single-cycle done pulse with extended load data.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [1:0]       state;
  logic [2:0]       cnt;
  logic             wr_q;
  logic [2:0]       op_q;
  logic [1:0]       off_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;

  mem_req_t in_req;
  logic     in_bad;
  logic     acc_fire;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH_WORDS];
  logic [NUM_LANES-1:0][7:0] cur_word;
  logic [NUM_LANES-1:0][7:0] st_word;
  logic [NUM_LANES-1:0]      st_mask;
  logic [31:0]               ld_data;

  assign in_req    = '{write: req_write, op: req_op, addr: req_addr, wdata: req_wdata};
  assign in_bad    = mem_req_illegal(in_req, DEPTH_WORDS);
  assign req_ready = (state == S_IDLE);
  assign acc_fire  = (state == S_WAIT) && (cnt == 3'd0);
  assign cur_word  = mem[idx_q];

  byte_lane_align u_align (
    .word    (cur_word),
    .wdata   (wdata_q),
    .off     (off_q),
    .op      (op_q),
    .ld_data (ld_data),
    .st_word (st_word),
    .st_mask (st_mask)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 3'd0;
      wr_q    <= 1'b0;
      op_q    <= 3'd0;
      off_q   <= 2'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          wr_q    <= in_req.write;
          op_q    <= in_req.op;
          off_q   <= in_req.addr[1:0];
          idx_q   <= in_req.addr[IDX_W+1:2];
          wdata_q <= in_req.wdata;
          if (in_bad) begin
            state <= S_RESP;
            done  <= 1'b1;
            error <= 1'b1;
            rdata <= '0;
          end else begin
            state <= S_WAIT;
            cnt   <= 3'(WAIT_STATES);
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            state <= S_RESP;
            done  <= 1'b1;
            error <= 1'b0;
            rdata <= wr_q ? 32'h0 : ld_data;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          error <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage has no reset; a store only lands on its commit edge, never under reset.
  always_ff @(posedge clk) begin
    if (rst && acc_fire && wr_q) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (st_mask[i]) mem[idx_q][i] <= st_word[i];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed checks of data_mem_responder against a byte-array model,
// with three instances covering wait-state counts 1, 3 and 0.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int NB    = 4 * DEPTH;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic        req_write;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ready;
  logic [2:0]  done;
  logic [2:0]  error;
  logic [31:0] rdata [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mb [3][NB];
  bit         mk [3][NB];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_write (req_write),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready[g]),
      .done      (done[g]),
      .rdata     (rdata[g]),
      .error     (error[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  function automatic int size_of(input logic [2:0] op);
    return (op == 3'd0 || op == 3'd4) ? 1 : ((op == 3'd1 || op == 3'd5) ? 2 : 4);
  endfunction

  function automatic bit m_illegal(input logic wr, input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd3 || op > 3'd5) return 1;
    if (wr && op >= 3'd4) return 1;
    if (a % size_of(op) != 0) return 1;
    if (a / 4 >= DEPTH) return 1;
    return 0;
  endfunction

  task automatic m_load(input int k, input logic [2:0] op, input logic [31:0] a,
                        output logic [31:0] v, output bit kn);
    int n;
    n  = size_of(op);
    v  = 32'h0;
    kn = 1;
    for (int i = 0; i < n; i++) begin
      v  = v | (32'(mb[k][int'(a) + i]) << (8 * i));
      kn = kn & mk[k][int'(a) + i];
    end
    if (op == 3'd0 && v >= 32'h80)   v = v + 32'hFFFFFF00;
    if (op == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
  endtask

  task automatic m_store(input int k, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd);
    for (int i = 0; i < size_of(op); i++) begin
      mb[k][int'(a) + i] = 8'(wd >> (8 * i));
      mk[k][int'(a) + i] = 1;
    end
  endtask

  // One request on instance k; checks latency, ready, error, rdata and the pulse width.
  task automatic txn(input int k, input logic wr, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd);
    bit          bad;
    bit          kn;
    logic [31:0] exp;
    int          lat;
    bad = m_illegal(wr, op, addr);
    exp = 32'h0;
    kn  = 1;
    if (!bad && !wr) m_load(k, op, addr, exp, kn);
    @(negedge clk);
    chk("ready_idle", 32'(req_ready[k]), 32'd1);
    req_write    = wr;
    req_op       = op;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid[k] = 1'b1;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (done[k]) lat = i;
      else chk("ready_busy", 32'(req_ready[k]), 32'd0);
    end
    chk("latency", 32'(lat), bad ? 32'd0 : 32'(1 + ws_of(k)));
    chk("error", 32'(error[k]), 32'(bad));
    chk("ready_resp", 32'(req_ready[k]), 32'd0);
    if (kn) chk("rdata", rdata[k], exp);
    rd = rdata[k];
    @(negedge clk);
    chk("done_pulse", 32'(done[k]), 32'd0);
    if (!bad && wr) m_store(k, op, addr, wd);
  endtask

  initial begin
    logic [31:0] rd;
    int          seen;
    int          last;
    bit          prev_done;
    logic [31:0] hv;

    rst       = 1'b0;
    req_valid = 3'b000;
    req_write = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NB; i++) mk[k][i] = 0;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_done", 32'(done[k]), 32'd0);
      chk("rst_error", 32'(error[k]), 32'd0);
      chk("rst_rdata", rdata[k], 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("rst_ready", 32'(req_ready[k]), 32'd1);

    for (int w = 0; w < DEPTH; w++) txn(0, 1'b1, 3'd2, 32'(4 * w), $urandom, rd);

    // Directed word / byte / half / error sequence, WAIT_STATES = 1
    txn(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd);
    txn(0, 1'b0, 3'd2, 32'h10, 32'h0, rd);   chk("lw10", rd, 32'hDEADBEEF);
    txn(0, 1'b1, 3'd0, 32'h13, 32'h80, rd);
    txn(0, 1'b0, 3'd0, 32'h13, 32'h0, rd);   chk("lb13", rd, 32'hFFFFFF80);
    txn(0, 1'b0, 3'd4, 32'h13, 32'h0, rd);   chk("lbu13", rd, 32'h00000080);
    txn(0, 1'b0, 3'd2, 32'h10, 32'h0, rd);   chk("lw10_b", rd, 32'h80ADBEEF);
    txn(0, 1'b1, 3'd1, 32'h12, 32'h8001, rd);
    txn(0, 1'b0, 3'd1, 32'h12, 32'h0, rd);   chk("lh12", rd, 32'hFFFF8001);
    txn(0, 1'b0, 3'd5, 32'h12, 32'h0, rd);   chk("lhu12", rd, 32'h00008001);
    txn(0, 1'b0, 3'd2, 32'h11, 32'h0, rd);   chk("err_lw11", rd, 32'h0);
    txn(0, 1'b0, 3'd1, 32'h01, 32'h0, rd);   chk("err_lh01", rd, 32'h0);
    txn(0, 1'b1, 3'd4, 32'h10, 32'hFF, rd);  chk("err_sbu", rd, 32'h0);
    txn(0, 1'b0, 3'd3, 32'h10, 32'h0, rd);   chk("err_op3", rd, 32'h0);
    txn(0, 1'b0, 3'd2, 32'(NB), 32'h0, rd);  chk("err_oob", rd, 32'h0);
    txn(0, 1'b0, 3'd2, 32'h10, 32'h0, rd);   chk("lw10_kept", rd, 32'h8001BEEF);

    for (int t = 0; t < 300; t++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 7);
      a = (r == 0) ? 32'($urandom_range(NB, NB + 32)) : 32'($urandom_range(0, NB - 1));
      if (r >= 4) a = a & ~32'h3;
      txn(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd);
    end

    // Reset during WAIT drops the pending store, WAIT_STATES = 3
    txn(1, 1'b1, 3'd2, 32'h20, 32'hAAAAAAAA, rd);
    txn(1, 1'b0, 3'd2, 32'h20, 32'h0, rd);
    @(negedge clk);
    req_write    = 1'b1;
    req_op       = 3'd2;
    req_addr     = 32'h20;
    req_wdata    = 32'h12345678;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("abort_in_wait", 32'(req_ready[1]), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("abort_rst_done", 32'(done[1]), 32'd0);
    chk("abort_rst_rdata", rdata[1], 32'h0);
    chk("abort_rst_ready", 32'(req_ready[1]), 32'd1);
    #1 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done[1]) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    txn(1, 1'b0, 3'd2, 32'h20, 32'h0, rd);   chk("abort_lw20", rd, 32'hAAAAAAAA);

    // Back-to-back handshake with valid held high, WAIT_STATES = 0
    hv = $urandom;
    @(negedge clk);
    req_write    = 1'b1;
    req_op       = 3'd2;
    req_addr     = 32'h40;
    req_wdata    = hv;
    req_valid[2] = 1'b1;
    last      = -1;
    prev_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (req_ready[2]) begin
        if (last >= 0) chk("hs_spacing", 32'(c - last), 32'd3);
        last = c;
      end
      chk("hs_done_pair", 32'(done[2] & prev_done), 32'd0);
      chk("hs_ready_done", 32'(done[2] & req_ready[2]), 32'd0);
      prev_done = done[2];
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
    for (int i = 0; i < 10 && !req_ready[2]; i++) @(negedge clk);
    chk("hs_idle", 32'(req_ready[2]), 32'd1);
    m_store(2, 3'd2, 32'h40, hv);
    txn(2, 1'b0, 3'd2, 32'h40, 32'h0, rd);   chk("hs_lw40", rd, hv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder side of the memory-stage data interface: accepts one load/store request at a time from the `memory` pipeline stage and completes it after a fixed number of wait states. It owns the data storage array, performs little-endian byte/half/word lane handling with sign/zero extension, and returns a one-cycle `done` pulse with read data. It replaces the direct single-cycle `ram` hookup.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words of storage; legal byte addresses 0 .. 4*DEPTH_WORDS-1.
- `WAIT_STATES`, 1: extra cycles before the access is performed; legal range 0..7.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_write`  in  1  1 = store, 0 = load.
- `req_op`  in  3  RV32 funct3 encoding:
  - 000 = B
  - 001 = H
  - 010 = W
  - 100 = BU
  - 101 = HU
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load result, extended to 32 bits.
- `error`  out  1  valid with `done`; request was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On accept, latch write, op, addr and wdata, then check legality.
  - Illegal request: go to RESP with `error` = 1. Nothing is written.
  - Legal request: go to WAIT with counter = WAIT_STATES.
- WAIT:
  - If counter == 0, perform the access on this edge and go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - `done` = 1 for exactly one cycle, then go to IDLE.
  - `req_valid` is ignored while in RESP.
- Illegal request, any of:
  - `req_op` is 011, 110 or 111.
  - Store with op BU or HU.
  - Misalignment: H/HU with `addr[0]` = 1, or W with `addr[1:0]` ≠ 0.
  - `addr[31:2]` ≥ DEPTH_WORDS.
- Loads:
  - Lane selection uses `addr[1:0]`, little-endian.
  - B and H sign-extend; BU and HU zero-extend; W returns the whole word.
- Stores:
  - B writes only the byte lane `addr[1:0]` with `wdata[7:0]`.
  - H writes lanes {addr[1], 0}+0..1 with `wdata[15:0]`.
  - W writes the whole word. Untouched lanes keep their contents.
- `rdata` is updated only on entry to RESP:
  - Load: the load value.
  - Store or error: 0.
  - Holds its value otherwise.
- Storage is not cleared by reset; its contents are undefined at power-up.

## Timing
- Reset values: `done` = 0, `error` = 0, `rdata` = 0, state = IDLE, counter = 0. `req_ready` = 1 after reset is released.
- Legal request accepted at edge E0:
  - Access (write commit or read sample) at edge E0+1+WAIT_STATES.
  - `done` high in the cycle after that edge.
- Illegal request accepted at E0: `done`/`error` high in the cycle after E0.
- Maximum throughput is one request per WAIT_STATES+3 cycles. `req_ready` is low in WAIT and RESP.
- A store followed immediately by a load to the same address returns the new data, because the write commits before the second request is accepted.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - A pending store whose commit edge has not occurred is dropped; storage is never partially written.
  - `done` is forced low.
- The counter saturates at 0 and never wraps.

## Structure
- Package `mem_pkg`:
  - funct3 constants `MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`.
  - FSM state encoding.
  - Shared with `memory` and `decode`.
- Sub-module `byte_lane_align` (combinational):
  - Load extract/extend: word, addr[1:0], op → rdata.
  - Store merge: old word, wdata, addr[1:0], op → new word and 4-bit lane mask.
- Storage is a register array inside `data_mem_responder`.

## Test plan
- WAIT_STATES = 1:
  - SW 0xDEADBEEF to 0x10, then LW 0x10.
  - Required: each `done` is 2 cycles after its accept edge; rdata = 0xDEADBEEF; error = 0.
- Byte lanes:
  - SB 0x80 to 0x13, then LB 0x13, then LBU 0x13, then LW 0x10.
  - Required: 0xFFFFFF80, then 0x00000080, then 0x80ADBEEF.
- Halves:
  - SH 0x8001 to 0x12, then LH 0x12, then LHU 0x12.
  - Required: 0xFFFF8001, then 0x00008001.
- Errors:
  - LW 0x11, LH 0x01, SBU (store with op 100), op 011, and LW to 4*DEPTH_WORDS.
  - Required for each: `done` and `error` high in the cycle after accept, rdata = 0, storage unchanged.
- Reset mid-operation:
  - WAIT_STATES = 3; SW 0x12345678 to 0x20 over old word 0xAAAAAAAA.
  - Pulse `rst` low during WAIT, then LW 0x20.
  - Required: returns 0xAAAAAAAA; no `done` pulse for the aborted store.
- Handshake:
  - Hold `req_valid` high continuously with WAIT_STATES = 0.
  - Required: accepts spaced exactly 3 cycles apart; `req_ready` low during WAIT and RESP; `done` never high for two consecutive cycles.
